// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NREQ requesters.
// A grant is held for a whole packet, up to MAX_BURST bytes, or until the owner stalls too long.
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int MAX_BURST     = 16,
    parameter int STALL_TIMEOUT = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_byte,
    input  logic                tx_ready,
    output logic [2:0]          grant_id,
    output logic                busy
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t     state, state_nx;
    logic [2:0] rr_ptr, rr_ptr_nx, grant_nx, rr_next, winner;
    logic [7:0] burst_cnt, burst_nx, stall_cnt, stall_nx;
    logic [7:0] g_data;
    logic [3:0] idx;
    logic       g_valid, g_last, fire, found;

    // Owner's request lines, selected by grant_id.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == grant_id) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

    // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        idx    = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= 4'(NREQ))
                idx = idx - 4'(NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (!found && idx == 4'(i) && req_valid[i]) begin
                    found  = 1'b1;
                    winner = 3'(i);
                end
            end
        end
    end

    // Handshake: a byte moves on a cycle where tx_valid and tx_ready are both high;
    // the owner's req_ready mirrors that same cycle, and nothing moves while reset is high.
    assign busy     = (state == XFER) && !reset;
    assign tx_valid = busy && g_valid;
    assign tx_byte  = tx_valid ? g_data : 8'h00;
    assign fire     = tx_valid && tx_ready;
    assign rr_next  = (grant_id == 3'(NREQ-1)) ? 3'd0 : grant_id + 3'd1;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = fire && (3'(i) == grant_id);
    end

    always_comb begin
        state_nx  = state;
        rr_ptr_nx = rr_ptr;
        grant_nx  = grant_id;
        burst_nx  = burst_cnt;
        stall_nx  = stall_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = XFER;
                    grant_nx = winner;
                    burst_nx = 8'd0;
                    stall_nx = 8'd0;
                end
            end
            XFER: begin
                if (fire) begin
                    burst_nx = burst_cnt + 8'd1;
                    stall_nx = 8'd0;
                    if (g_last || burst_cnt == 8'(MAX_BURST-1)) begin
                        state_nx  = IDLE;
                        rr_ptr_nx = rr_next;
                    end
                end else if (!g_valid) begin
                    // Backpressure (valid high, ready low) is not a stall.
                    stall_nx = stall_cnt + 8'd1;
                    if (stall_cnt == 8'(STALL_TIMEOUT-1)) begin
                        state_nx  = IDLE;
                        rr_ptr_nx = rr_next;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 3'd0;
            grant_id  <= 3'd0;
            burst_cnt <= 8'd0;
            stall_cnt <= 8'd0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_ptr_nx;
            grant_id  <= grant_nx;
            burst_cnt <= burst_nx;
            stall_cnt <= stall_nx;
        end
    end

endmodule
